adc7478_capture: RTL and testbench

- Serial front-end for the AD7478 8-bit ADC that digitises the LT5534 RSS envelope.
- Sits directly upstream of the loctag control FSM: it consumes the FSM's level-type start request and returns a one-cycle eoc pulse with an 8-bit result, which the FSM writes into the 11b payload ROM.
- Generates adc_cs and adc_clk from the 50 MHz system clock, deserialises adc_so and optionally averages 2^AVG_LOG2 conversions.

---
 rtl/loctag_pkg.sv | 17 +
 rtl/adc_sclk_gen.sv | 58 +++++
 rtl/adc7478_capture.sv | 148 ++++++++++++++
 tb/tb_adc7478_capture.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/loctag_pkg.sv
// Shared types and frame constants for the loctag ADC capture path.
package loctag_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_CAPTURE,
    ST_QUIET
  } adc_state_e;

  localparam int unsigned ADC_FRAME_BITS = 16;
  localparam int unsigned ADC_DATA_MSB   = 11;
  localparam int unsigned ADC_DATA_LSB   = 4;
  localparam int unsigned ADC_DATA_W     = ADC_DATA_MSB - ADC_DATA_LSB + 1;

endpackage

// File: rtl/adc_sclk_gen.sv
// ADC serial clock generator: HALF-cycle phase counter, adc_clk flop and frame bit counter.
module adc_sclk_gen
  import loctag_pkg::*;
#(
  parameter int unsigned HALF = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_tick_c_o,
  output logic frame_done_c_o
);

  localparam int unsigned PH_W  = (HALF > 1) ? $clog2(HALF) : 1;
  localparam int unsigned BIT_W = $clog2(ADC_FRAME_BITS + 1);

  logic [PH_W-1:0]  ph_q, ph_d;
  logic             sclk_q, sclk_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic             ph_end;

  // Phase counts down; zero means the current half period is finished.
  assign ph_end         = (ph_q == '0);
  assign rise_tick_c_o  = ph_end & ~sclk_q;
  assign frame_done_c_o = ph_end & sclk_q & (bit_q == BIT_W'(ADC_FRAME_BITS));
  assign sclk_o         = sclk_q;

  always_comb begin
    ph_d   = ph_q;
    sclk_d = sclk_q;
    bit_d  = bit_q;
    if (!en_i) begin
      ph_d   = '0;
      sclk_d = 1'b1;
      bit_d  = '0;
    end else if (ph_end) begin
      ph_d   = PH_W'(HALF - 1);
      sclk_d = ~sclk_q;
      if (!sclk_q) bit_d = bit_q + BIT_W'(1);
    end else begin
      ph_d = ph_q - PH_W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ph_q   <= '0;
      sclk_q <= 1'b1;
      bit_q  <= '0;
    end else begin
      ph_q   <= ph_d;
      sclk_q <= sclk_d;
      bit_q  <= bit_d;
    end
  end

endmodule

// File: rtl/adc7478_capture.sv
// AD7478 serial capture front-end: frames adc_cs/adc_clk, deserialises adc_so and
// averages 2^AVG_LOG2 conversions per start request.
module adc7478_capture
  import loctag_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 4,
  parameter int unsigned QUIET_CYC = 3,
  parameter int unsigned AVG_LOG2  = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  output logic       adc_cs,
  output logic       adc_clk,
  input  logic       adc_so,
  output logic       busy,
  output logic       eoc,
  output logic [7:0] data,
  output logic       frame_err
);

  localparam int unsigned HALF    = CLK_DIV / 2;
  localparam int unsigned NCONV   = 1 << AVG_LOG2;
  localparam int unsigned SUM_W   = ADC_DATA_W + AVG_LOG2;
  localparam int unsigned CONV_W  = AVG_LOG2 + 1;
  localparam int unsigned CNT_MAX = (HALF > QUIET_CYC) ? HALF : QUIET_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  adc_state_e                state_q, state_d;
  logic                      start_q;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CONV_W-1:0]         conv_q, conv_d;
  logic [SUM_W-1:0]          sum_q, sum_d;
  logic [ADC_FRAME_BITS-1:0] shreg_q, shreg_d;
  logic                      cs_q, cs_d;
  logic                      busy_q, busy_d;
  logic                      eoc_q, eoc_d;
  logic [7:0]                data_q, data_d;
  logic                      ferr_q, ferr_d;
  logic                      rise_tick_c, frame_done_c, sclk;

  adc_sclk_gen #(.HALF(HALF)) u_sclk (
    .clk_i          (clk),
    .rst_i          (reset),
    .en_i           (state_d == ST_SHIFT),
    .sclk_o         (sclk),
    .rise_tick_c_o  (rise_tick_c),
    .frame_done_c_o (frame_done_c)
  );

  // Capture math runs on the SHIFT->CAPTURE edge so eoc/data are visible in the CAPTURE cycle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    conv_d  = conv_q;
    sum_d   = sum_q;
    shreg_d = shreg_q;
    data_d  = data_q;
    ferr_d  = ferr_q;
    eoc_d   = 1'b0;

    if (state_q == ST_SHIFT && rise_tick_c)
      shreg_d = {shreg_q[ADC_FRAME_BITS-2:0], adc_so};

    case (state_q)
      ST_IDLE: begin
        if (start && !start_q) begin
          state_d = ST_SETUP;
          cnt_d   = '0;
          conv_d  = '0;
          sum_d   = '0;
          ferr_d  = 1'b0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == CNT_W'(HALF - 1)) state_d = ST_SHIFT;
        else                           cnt_d   = cnt_q + CNT_W'(1);
      end
      ST_SHIFT: begin
        if (frame_done_c) begin
          state_d = ST_CAPTURE;
          sum_d   = sum_q + SUM_W'(shreg_q[ADC_DATA_MSB:ADC_DATA_LSB]);
          conv_d  = conv_q + CONV_W'(1);
          if ((|shreg_q[ADC_FRAME_BITS-1:ADC_DATA_MSB+1]) || (|shreg_q[ADC_DATA_LSB-1:0]))
            ferr_d = 1'b1;
          if (conv_d == CONV_W'(NCONV)) begin
            data_d = 8'(sum_d >> AVG_LOG2);
            eoc_d  = 1'b1;
          end
        end
      end
      ST_CAPTURE: begin
        state_d = ST_QUIET;
        cnt_d   = '0;
      end
      ST_QUIET: begin
        if (cnt_q == CNT_W'(QUIET_CYC - 1)) begin
          cnt_d   = '0;
          state_d = (conv_q == CONV_W'(NCONV)) ? ST_IDLE : ST_SETUP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cs_d   = !(state_d == ST_SETUP || state_d == ST_SHIFT);
    busy_d = !(state_d == ST_IDLE ||
               (state_d == ST_QUIET && cnt_d == CNT_W'(QUIET_CYC - 1) &&
                conv_d == CONV_W'(NCONV)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      start_q <= 1'b0;
      cnt_q   <= '0;
      conv_q  <= '0;
      sum_q   <= '0;
      shreg_q <= '0;
      cs_q    <= 1'b1;
      busy_q  <= 1'b0;
      eoc_q   <= 1'b0;
      data_q  <= '0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start;
      cnt_q   <= cnt_d;
      conv_q  <= conv_d;
      sum_q   <= sum_d;
      shreg_q <= shreg_d;
      cs_q    <= cs_d;
      busy_q  <= busy_d;
      eoc_q   <= eoc_d;
      data_q  <= data_d;
      ferr_q  <= ferr_d;
    end
  end

  assign adc_cs    = cs_q;
  assign adc_clk   = sclk;
  assign busy      = busy_q;
  assign eoc       = eoc_q;
  assign data      = data_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_adc7478_capture.sv
// Self-checking bench for adc7478_capture: default instance plus a 4-way averaging instance.
module tb_adc7478_capture;

  typedef struct packed {
    logic [7:0] data;
    logic       ferr;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       start0 = 1'b0, start1 = 1'b0;
  logic       adc_so0 = 1'b0, adc_so1 = 1'b0;
  logic       adc_cs0, adc_clk0, busy0, eoc0, ferr0;
  logic       adc_cs1, adc_clk1, busy1, eoc1, ferr1;
  logic [7:0] data0, data1;

  int errors = 0;
  int checks = 0;

  logic [15:0] frames0[$], frames1[$];
  exp_t        exp0[$], exp1[$];

  adc7478_capture dut (
    .clk(clk), .reset(reset), .start(start0), .adc_cs(adc_cs0), .adc_clk(adc_clk0),
    .adc_so(adc_so0), .busy(busy0), .eoc(eoc0), .data(data0), .frame_err(ferr0)
  );

  adc7478_capture #(.CLK_DIV(4), .QUIET_CYC(3), .AVG_LOG2(2)) dut_avg (
    .clk(clk), .reset(reset), .start(start1), .adc_cs(adc_cs1), .adc_clk(adc_clk1),
    .adc_so(adc_so1), .busy(busy1), .eoc(eoc1), .data(data1), .frame_err(ferr1)
  );

  always #10 clk = ~clk;

  // ADC models: new frame on cs fall, next MSB-first bit after each adc_clk fall.
  logic [15:0] cur0 = '0, cur1 = '0;
  int          idx0 = 0, idx1 = 0;
  logic        csp0 = 1'b1, sckp0 = 1'b1, csp1 = 1'b1, sckp1 = 1'b1;

  always @(negedge clk) begin
    if (!adc_cs0 && csp0) cur0 = (frames0.size() > 0) ? frames0.pop_front() : 16'h0000;
    if (!adc_cs0 && sckp0 && !adc_clk0 && idx0 < 16) begin
      adc_so0 = cur0[4'(15 - idx0)];
      idx0++;
    end
    if (adc_cs0) idx0 = 0;
    csp0  = adc_cs0;
    sckp0 = adc_clk0;
  end

  always @(negedge clk) begin
    if (!adc_cs1 && csp1) cur1 = (frames1.size() > 0) ? frames1.pop_front() : 16'h0000;
    if (!adc_cs1 && sckp1 && !adc_clk1 && idx1 < 16) begin
      adc_so1 = cur1[4'(15 - idx1)];
      idx1++;
    end
    if (adc_cs1) idx1 = 0;
    csp1  = adc_cs1;
    sckp1 = adc_clk1;
  end

  // Scoreboards: every eoc pops one expected result.
  always @(negedge clk) begin
    exp_t e;
    if (eoc0) begin
      checks++;
      if (exp0.size() == 0) begin
        errors++;
        $display("FAIL sb0_unexpected_eoc data=%h", data0);
      end else begin
        e = exp0.pop_front();
        if (data0 !== e.data || ferr0 !== e.ferr) begin
          errors++;
          $display("FAIL sb0_result got data=%h ferr=%b exp data=%h ferr=%b",
                   data0, ferr0, e.data, e.ferr);
        end
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (eoc1) begin
      checks++;
      if (exp1.size() == 0) begin
        errors++;
        $display("FAIL sb1_unexpected_eoc data=%h", data1);
      end else begin
        e = exp1.pop_front();
        if (data1 !== e.data || ferr1 !== e.ferr) begin
          errors++;
          $display("FAIL sb1_result got data=%h ferr=%b exp data=%h ferr=%b",
                   data1, ferr1, e.data, e.ferr);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset;
    #1 reset = 1'b1;
    cyc(3);
    checks += 7;
    if (adc_cs0 !== 1'b1)  begin errors++; $display("FAIL rst_cs got=%b exp=1", adc_cs0); end
    if (adc_clk0 !== 1'b1) begin errors++; $display("FAIL rst_sclk got=%b exp=1", adc_clk0); end
    if (busy0 !== 1'b0)    begin errors++; $display("FAIL rst_busy got=%b exp=0", busy0); end
    if (eoc0 !== 1'b0)     begin errors++; $display("FAIL rst_eoc got=%b exp=0", eoc0); end
    if (data0 !== 8'h00)   begin errors++; $display("FAIL rst_data got=%h exp=00", data0); end
    if (ferr0 !== 1'b0)    begin errors++; $display("FAIL rst_ferr got=%b exp=0", ferr0); end
    if (adc_cs1 !== 1'b1)  begin errors++; $display("FAIL rst_cs_avg got=%b exp=1", adc_cs1); end
    reset = 1'b0;
    cyc(3);
  endtask

  task automatic test_latency;
    int cs_low = -1, first_fall = -1, eoc_cyc = -1, busy_low = -1, falls = 0, eocs = 0;
    logic prev_sclk = 1'b1, busy_seen = 1'b0;
    frames0.push_back(16'h0A50);
    exp0.push_back(exp_t'{8'hA5, 1'b0});
    start0 = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      @(negedge clk);
      if (!adc_cs0 && cs_low < 0) cs_low = c;
      if (prev_sclk && !adc_clk0) begin
        falls++;
        if (first_fall < 0) first_fall = c;
      end
      prev_sclk = adc_clk0;
      if (eoc0) begin
        eocs++;
        if (eoc_cyc < 0) eoc_cyc = c;
      end
      if (busy0) busy_seen = 1'b1;
      else if (busy_seen && busy_low < 0) busy_low = c;
    end
    start0 = 1'b0;
    checks += 6;
    if (cs_low != 1)      begin errors++; $display("FAIL lat_cs_low got=%0d exp=1", cs_low); end
    if (first_fall != 3)  begin errors++; $display("FAIL lat_first_fall got=%0d exp=3", first_fall); end
    if (falls != 16)      begin errors++; $display("FAIL lat_sclk_periods got=%0d exp=16", falls); end
    if (eoc_cyc != 67)    begin errors++; $display("FAIL lat_eoc got=%0d exp=67", eoc_cyc); end
    if (eocs != 1)        begin errors++; $display("FAIL lat_eoc_count got=%0d exp=1", eocs); end
    if (busy_low != 70)   begin errors++; $display("FAIL lat_busy_low got=%0d exp=70", busy_low); end
    cyc(3);
  endtask

  task automatic test_held_start;
    int eocs = 0;
    frames0.push_back(16'h0770);
    exp0.push_back(exp_t'{8'h77, 1'b0});
    start0 = 1'b1;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (eoc0) eocs++;
    end
    start0 = 1'b0;
    checks++;
    if (eocs != 1) begin errors++; $display("FAIL held_eoc_count got=%0d exp=1", eocs); end
    cyc(2);
    frames0.push_back(16'h03C0);
    exp0.push_back(exp_t'{8'h3C, 1'b0});
    eocs = 0;
    start0 = 1'b1;
    for (int c = 0; c < 150; c++) begin
      @(negedge clk);
      if (eoc0) eocs++;
    end
    start0 = 1'b0;
    checks += 2;
    if (eocs != 1)       begin errors++; $display("FAIL rearm_eoc_count got=%0d exp=1", eocs); end
    if (data0 !== 8'h3C) begin errors++; $display("FAIL rearm_data got=%h exp=3c", data0); end
    cyc(2);
  endtask

  task automatic test_frame_err;
    frames0.push_back(16'h8A50);
    exp0.push_back(exp_t'{8'hA5, 1'b1});
    start0 = 1'b1;
    cyc(100);
    start0 = 1'b0;
    cyc(2);
    checks++;
    if (ferr0 !== 1'b1) begin errors++; $display("FAIL ferr_sticky got=%b exp=1", ferr0); end
    frames0.push_back(16'h0120);
    exp0.push_back(exp_t'{8'h12, 1'b0});
    start0 = 1'b1;
    cyc(2);
    checks++;
    if (ferr0 !== 1'b0) begin errors++; $display("FAIL ferr_clear_on_accept got=%b exp=0", ferr0); end
    cyc(98);
    start0 = 1'b0;
    checks++;
    if (ferr0 !== 1'b0) begin errors++; $display("FAIL ferr_clean_frame got=%b exp=0", ferr0); end
    cyc(2);
  endtask

  task automatic test_reset_mid;
    int falls = 0, eocs = 0;
    logic prev_sclk = 1'b1;
    frames0.push_back(16'h0FF0);
    start0 = 1'b1;
    for (int c = 0; c < 100 && falls < 8; c++) begin
      @(negedge clk);
      if (prev_sclk && !adc_clk0) falls++;
      prev_sclk = adc_clk0;
    end
    checks++;
    if (falls != 8) begin errors++; $display("FAIL rstmid_reach_8th got=%0d exp=8", falls); end
    #2 reset = 1'b1;
    #1;
    checks += 4;
    if (adc_cs0 !== 1'b1)  begin errors++; $display("FAIL rstmid_cs got=%b exp=1", adc_cs0); end
    if (adc_clk0 !== 1'b1) begin errors++; $display("FAIL rstmid_sclk got=%b exp=1", adc_clk0); end
    if (busy0 !== 1'b0)    begin errors++; $display("FAIL rstmid_busy got=%b exp=0", busy0); end
    if (data0 !== 8'h00)   begin errors++; $display("FAIL rstmid_data got=%h exp=00", data0); end
    @(negedge clk);
    reset = 1'b0;
    start0 = 1'b0;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk);
      if (eoc0) eocs++;
    end
    checks += 2;
    if (eocs != 0)       begin errors++; $display("FAIL rstmid_no_eoc got=%0d exp=0", eocs); end
    if (data0 !== 8'h00) begin errors++; $display("FAIL rstmid_data_hold got=%h exp=00", data0); end
  endtask

  task automatic test_start_fall;
    int eoc_cyc = -1, eocs = 0, late_cs = 0;
    frames0.push_back(16'h0550);
    exp0.push_back(exp_t'{8'h55, 1'b0});
    start0 = 1'b1;
    cyc(20);
    start0 = 1'b0;
    for (int c = 21; c <= 250; c++) begin
      @(negedge clk);
      if (eoc0) begin
        eocs++;
        if (eoc_cyc < 0) eoc_cyc = c;
      end
      if (eoc_cyc > 0 && c == eoc_cyc + 1) start0 = 1'b1;
      if (eoc_cyc > 0 && c > eoc_cyc && !adc_cs0) late_cs++;
    end
    start0 = 1'b0;
    checks += 4;
    if (eoc_cyc != 67) begin errors++; $display("FAIL fall_eoc_cycle got=%0d exp=67", eoc_cyc); end
    if (eocs != 1)     begin errors++; $display("FAIL quiet_edge_eocs got=%0d exp=1", eocs); end
    if (late_cs != 0)  begin errors++; $display("FAIL quiet_edge_cs_low got=%0d exp=0", late_cs); end
    if (busy0 !== 1'b0) begin errors++; $display("FAIL quiet_edge_busy got=%b exp=0", busy0); end
    cyc(2);
  endtask

  task automatic test_avg;
    int windows = 0, high_run = 0, min_gap = 1000, eocs = 0, eoc_cyc = -1;
    logic prev_cs = 1'b1;
    frames1.push_back(16'h0100);
    frames1.push_back(16'h0110);
    frames1.push_back(16'h0120);
    frames1.push_back(16'h0140);
    exp1.push_back(exp_t'{8'h11, 1'b0});
    start1 = 1'b1;
    for (int c = 1; c <= 320; c++) begin
      @(negedge clk);
      if (prev_cs && !adc_cs1) begin
        windows++;
        if (windows > 1 && high_run < min_gap) min_gap = high_run;
        high_run = 0;
      end
      if (adc_cs1) high_run++;
      prev_cs = adc_cs1;
      if (eoc1) begin
        eocs++;
        if (eoc_cyc < 0) eoc_cyc = c;
      end
    end
    start1 = 1'b0;
    checks += 6;
    if (windows != 4)    begin errors++; $display("FAIL avg_cs_windows got=%0d exp=4", windows); end
    if (min_gap < 3)     begin errors++; $display("FAIL avg_min_gap got=%0d exp>=3", min_gap); end
    if (eocs != 1)       begin errors++; $display("FAIL avg_eoc_count got=%0d exp=1", eocs); end
    if (eoc_cyc != 277)  begin errors++; $display("FAIL avg_eoc_cycle got=%0d exp=277", eoc_cyc); end
    if (data1 !== 8'h11) begin errors++; $display("FAIL avg_data got=%h exp=11", data1); end
    if (busy1 !== 1'b0)  begin errors++; $display("FAIL avg_busy_end got=%b exp=0", busy1); end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_held_start();
    test_frame_err();
    test_reset_mid();
    test_start_fall();
    test_avg();
    cyc(5);
    checks += 2;
    if (exp0.size() != 0) begin errors++; $display("FAIL sb0_leftover got=%0d exp=0", exp0.size()); end
    if (exp1.size() != 0) begin errors++; $display("FAIL sb1_leftover got=%0d exp=0", exp1.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
